// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared defaults, drain FSM encoding and misc.in status bit positions.
package uart_rx_fifo_pkg;
  localparam int DEPTH_LOG2_DEF = 4;
  localparam int DW_DEF = 8;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK    = 2'd1,
    SETTLE = 2'd2
  } state_t;
  localparam int ST_TX_READY = 0;
  localparam int ST_RX_VALID = 1;
  localparam int ST_OVERFLOW = 2;
  function automatic logic [2:0] status_word(input logic tx_ready, input logic rx_valid, input logic overflow);
    logic [2:0] s;
    s = '0;
    s[ST_TX_READY] = tx_ready;
    s[ST_RX_VALID] = rx_valid;
    s[ST_OVERFLOW] = overflow;
    return s;
  endfunction
endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: buart drain handshake plus CPU pop/flush/status signals.
interface uart_rx_fifo_if
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int DW = DW_DEF
);
  logic uart_valid;
  logic [DW-1:0] uart_data;
  logic uart_rd;
  logic rd;
  logic clr;
  logic [DW-1:0] rd_data;
  logic rx_valid;
  logic [DEPTH_LOG2:0] count;
  logic overflow;
  modport master (
    output uart_valid, uart_data, rd, clr,
    input uart_rd, rd_data, rx_valid, count, overflow
  );
  modport slave (
    input uart_valid, uart_data, rd, clr,
    output uart_rd, rd_data, rx_valid, count, overflow
  );
endinterface

// File: rtl/uart_rx_fifo_mem.sv
// uart_rx_fifo_mem: small register file, one write port, asynchronous read port.
module uart_rx_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DW-1:0]         wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DW-1:0]         rdata
);
  logic [DW-1:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: drains buart into a show-ahead FIFO for the j1 io_din path.
// UART_RX_FIFO_DROP_EN selects drop-when-full with sticky overflow; default is backpressure.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int DW = DW_DEF
) (
  input logic clk,
  input logic resetq,
  uart_rx_fifo_if.slave bus
);
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
`ifdef UART_RX_FIFO_DROP_EN
  localparam logic DROP = 1'b1;
`else
  localparam logic DROP = 1'b0;
`endif
  state_t state, state_nx;
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic full, take, wr_en, pop;
  assign full  = count == FULL_CNT;
  assign take  = state == IDLE && bus.uart_valid && !bus.clr && (!full || DROP);
  assign wr_en = take && !full;
  assign pop   = bus.rd && count != '0 && !bus.clr;
  always_ff @(posedge clk)
    state <= resetq ? state_nx : IDLE;
  always_comb
    state_nx = state == IDLE ? (take ? ACK : IDLE) : state == ACK ? SETTLE : IDLE;
  always_comb
    bus.uart_rd = state == ACK;
  // clr shares the reset path for pointers and count; the FSM keeps running
  always_ff @(posedge clk) begin
    if (!resetq || bus.clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(pop);
    end
  end
`ifdef UART_RX_FIFO_DROP_EN
  logic overflow;
  always_ff @(posedge clk)
    overflow <= (!resetq || bus.clr) ? 1'b0 : overflow | (take & full);
  assign bus.overflow = overflow;
`else
  assign bus.overflow = 1'b0;
`endif
  uart_rx_fifo_mem #(.DEPTH_LOG2(DEPTH_LOG2), .DW(DW)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr),
    .wdata (bus.uart_data),
    .raddr (rptr),
    .rdata (bus.rd_data)
  );
  assign bus.rx_valid = count != '0;
  assign bus.count    = count;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_uart_rx_fifo;
  localparam int DL = 4;
  localparam int DEPTH = 2**DL;
`ifdef UART_RX_FIFO_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif
  logic clk = 1'b0;
  logic resetq = 1'b0;
  uart_rx_fifo_if #(.DEPTH_LOG2(DL), .DW(8)) bus ();
  uart_rx_fifo #(.DEPTH_LOG2(DL), .DW(8)) dut (
    .clk    (clk),
    .resetq (resetq),
    .bus    (bus)
  );
  always #5 clk = ~clk;
  byte unsigned src[$];
  byte unsigned mq[$];
  bit ovf = 1'b0;
  int cool = 0;
  int n_chk = 0;
  int n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic c);
    logic ack_now, valid, full, take, popm;
    byte unsigned d;
    valid = src.size() > 0;
    d = valid ? src[0] : 8'h00;
    bus.rd = r;
    bus.clr = c;
    bus.uart_valid = valid;
    bus.uart_data = d;
    ack_now = bus.uart_rd === 1'b1;
    if (!resetq) begin
      mq.delete();
      ovf = 1'b0;
      cool = 0;
    end else begin
      full = mq.size() == DEPTH;
      take = cool == 0 && valid && !c && (!full || DROP);
      popm = r && mq.size() != 0 && !c;
      if (c) begin
        mq.delete();
        ovf = 1'b0;
      end else begin
        if (popm) void'(mq.pop_front());
        if (take && !full) mq.push_back(d);
        if (take && full) ovf = 1'b1;
      end
      cool = take ? 2 : (cool > 0 ? cool - 1 : 0);
    end
    @(posedge clk);
    #1;
    if (ack_now && src.size() > 0) void'(src.pop_front());
    chk("count", 32'(bus.count), 32'(mq.size()));
    chk("rx_valid", 32'(bus.rx_valid), 32'(mq.size() != 0));
    chk("uart_rd", 32'(bus.uart_rd), 32'(cool == 2));
    chk("overflow", 32'(bus.overflow), 32'(ovf));
    if (mq.size() != 0) chk("rd_data", 32'(bus.rd_data), 32'(mq[0]));
  endtask
  task automatic settle(input int budget);
    int n;
    n = 0;
    while ((src.size() != 0 || cool != 0) && n < budget) begin
      step(1'b0, 1'b0);
      n++;
    end
    if (src.size() != 0 || cool != 0) chk("settle_timeout", 32'(n), 32'(budget + 1));
  endtask
  task automatic push_n(input int n, input byte unsigned base);
    for (int i = 0; i < n; i++) src.push_back(8'(base + i));
    settle(3 * n + 10);
  endtask
  initial begin
    int n;
    bus.rd = 1'b0;
    bus.clr = 1'b0;
    bus.uart_valid = 1'b0;
    bus.uart_data = 8'h00;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_uart_rd", 32'(bus.uart_rd), 0);
    chk("rst_rx_valid", 32'(bus.rx_valid), 0);
    resetq = 1'b1;
    step(1'b0, 1'b0);
    src.push_back(8'h41);
    step(1'b0, 1'b0);
    chk("single_ack", 32'(bus.uart_rd), 1);
    chk("single_data", 32'(bus.rd_data), 32'h41);
    settle(10);
    chk("single_count", 32'(bus.count), 1);
    step(1'b1, 1'b0);
    chk("single_pop", 32'(bus.count), 0);
    chk("single_empty", 32'(bus.rx_valid), 0);
    for (int i = 0; i < 16; i++) src.push_back(8'(i));
    src.push_back(8'hAA);
    for (int i = 0; i < 70; i++) step(1'b0, 1'b0);
    chk("burst_count", 32'(bus.count), 16);
    chk("burst_ovf", 32'(bus.overflow), 32'(DROP));
    chk("burst_uart_rd", 32'(bus.uart_rd), 0);
    for (int i = 0; i < 16; i++) begin
      chk("burst_pop", 32'(bus.rd_data), 32'(i));
      step(1'b1, 1'b0);
    end
    settle(10);
    chk("burst_left", 32'(bus.count), DROP ? 0 : 1);
    step(1'b0, 1'b1);
    for (int r = 0; r < 5; r++) begin
      push_n(10, 8'(8'h20 + 10 * r));
      for (int i = 0; i < 10; i++) begin
        chk("wrap_pop", 32'(bus.rd_data), 32'(8'h20 + 10 * r + i));
        step(1'b1, 1'b0);
      end
      chk("wrap_empty", 32'(bus.count), 0);
    end
    push_n(3, 8'h70);
    src.push_back(8'h73);
    step(1'b1, 1'b0);
    chk("simul_count", 32'(bus.count), 3);
    settle(10);
    for (int i = 1; i < 4; i++) begin
      chk("simul_order", 32'(bus.rd_data), 32'(8'h70 + i));
      step(1'b1, 1'b0);
    end
    step(1'b1, 1'b0);
    chk("empty_pop", 32'(bus.count), 0);
    push_n(DROP ? 17 : 16, 8'h80);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0);
    chk("flush_pre_count", 32'(bus.count), 5);
    chk("flush_pre_ovf", 32'(bus.overflow), 32'(DROP));
    step(1'b1, 1'b1);
    chk("flush_count", 32'(bus.count), 0);
    chk("flush_ovf", 32'(bus.overflow), 0);
    chk("flush_rx_valid", 32'(bus.rx_valid), 0);
    src.push_back(8'hC3);
    n = 0;
    while (bus.uart_rd !== 1'b1 && n < 10) begin
      step(1'b0, 1'b0);
      n++;
    end
    chk("midrst_ack_seen", 32'(bus.uart_rd), 1);
    resetq = 1'b0;
    step(1'b0, 1'b0);
    resetq = 1'b1;
    chk("midrst_uart_rd", 32'(bus.uart_rd), 0);
    chk("midrst_count", 32'(bus.count), 0);
    src.push_back(8'h5A);
    step(1'b0, 1'b0);
    chk("midrst_reack", 32'(bus.uart_rd), 1);
    settle(10);
    chk("midrst_data", 32'(bus.rd_data), 32'h5A);
    chk("midrst_count1", 32'(bus.count), 1);
    for (int i = 0; i < 1500; i++) begin
      if (src.size() < 3 && $urandom_range(0, 99) < 60) src.push_back(8'($urandom));
      step(1'($urandom_range(0, 99) < 25), 1'($urandom_range(0, 99) < 2));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
